multicycle_control: RTL

- Multicycle control FSM for the 32-bit datapath.
- Generates the operand-A select code (`sel_operA`) consumed by the operand-A mux, together with the operand-B select, ALU function, PC, IR, register-file and memory strobes.
- Sequences each instruction through fetch/decode/execute/memory/write-back states and waits on the memory ready handshake.

---
 rtl/multicycle_control_pkg.sv | 73 +++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control_alu_funct_decode.sv | 24 ++
 rtl/multicycle_control.sv | 132 +++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle control FSM: state encodings,
// opcode/funct values, ALU codes, operand select codes and the control payload.
package multicycle_control_pkg;

    localparam int unsigned OPW     = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned SELA_W  = 2;
    localparam int unsigned PCSRC_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_WB_ALU   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    localparam logic [OPW-1:0] FN_ADD = 6'b100000;
    localparam logic [OPW-1:0] FN_SUB = 6'b100010;
    localparam logic [OPW-1:0] FN_AND = 6'b100100;
    localparam logic [OPW-1:0] FN_OR  = 6'b100101;
    localparam logic [OPW-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    localparam logic [SELA_W-1:0] SELA_REG      = 2'b00;
    localparam logic [SELA_W-1:0] SELA_FOUR     = 2'b01;
    localparam logic [SELA_W-1:0] SELA_IMM_EXT  = 2'b10;
    localparam logic [SELA_W-1:0] SELA_IMM_DESP = 2'b11;

    localparam logic SELB_RS = 1'b0;
    localparam logic SELB_PC = 1'b1;

    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic               mem_req;
        logic               mem_we;
        logic               iord;
        logic               ir_write;
        logic               pc_write;
        logic [PCSRC_W-1:0] pc_src;
        logic               reg_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic [SELA_W-1:0]  sel_operA;
        logic               sel_operB;
        logic [ALU_W-1:0]   alu_ctrl;
        logic               illegal_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle; the controller is the master.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [OPW-1:0]     opcode;
    logic [OPW-1:0]     funct;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_we;
    logic               iord;
    logic               ir_write;
    logic               pc_write;
    logic [PCSRC_W-1:0] pc_src;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic [SELA_W-1:0]  sel_operA;
    logic               sel_operB;
    logic [ALU_W-1:0]   alu_ctrl;
    logic               illegal_op;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
               reg_dst, mem_to_reg, sel_operA, sel_operB, alu_ctrl,
               illegal_op, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
               reg_dst, mem_to_reg, sel_operA, sel_operB, alu_ctrl,
               illegal_op, state_dbg
    );

endinterface

// File: rtl/multicycle_control_alu_funct_decode.sv
// R-type funct field to ALU operation; valid_c flags a supported funct.
module alu_funct_decode
    import multicycle_control_pkg::*;
(
    input  logic [OPW-1:0]   funct,
    output logic [ALU_W-1:0] alu_ctrl_c,
    output logic             valid_c
);

    // Unsupported funct falls back to add so the ALU sees a benign operation.
    always_comb begin
        alu_ctrl_c = ALU_ADD;
        valid_c    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl_c = ALU_ADD;
            FN_SUB:  alu_ctrl_c = ALU_SUB;
            FN_AND:  alu_ctrl_c = ALU_AND;
            FN_OR:   alu_ctrl_c = ALU_OR;
            FN_SLT:  alu_ctrl_c = ALU_SLT;
            default: valid_c    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back and
// drives the datapath strobes combinationally from the current state.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);

    state_e           state_q;
    state_e           state_d;
    ctrl_t            ctrl_c;
    logic [ALU_W-1:0] fd_alu_c;
    logic             fd_valid_c;

    alu_funct_decode u_funct_dec (
        .funct      (bus.funct),
        .alu_ctrl_c (fd_alu_c),
        .valid_c    (fd_valid_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        ctrl_c  = '0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.sel_operA = SELA_FOUR;
                ctrl_c.sel_operB = SELB_PC;
                ctrl_c.alu_ctrl  = ALU_ADD;
                if (bus.mem_ready) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    ctrl_c.pc_src   = PCSRC_ALU;
                    state_d         = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            // Branch target is computed here, before the opcode is known.
            S_DECODE: begin
                ctrl_c.sel_operA = SELA_IMM_DESP;
                ctrl_c.sel_operB = SELB_PC;
                ctrl_c.alu_ctrl  = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        ctrl_c.illegal_op = 1'b1;
                        state_d           = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                ctrl_c.sel_operA  = SELA_REG;
                ctrl_c.sel_operB  = SELB_RS;
                ctrl_c.alu_ctrl   = fd_alu_c;
                ctrl_c.illegal_op = ~fd_valid_c;
                state_d           = fd_valid_c ? S_WB_ALU : S_FETCH;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctrl_c.sel_operA = SELA_IMM_EXT;
                ctrl_c.sel_operB = SELB_RS;
                ctrl_c.alu_ctrl  = ALU_ADD;
                if (state_q == S_EXEC_I)       state_d = S_WB_ALU;
                else if (bus.opcode == OP_LW)  state_d = S_MEM_RD;
                else                           state_d = S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.iord    = 1'b1;
                state_d        = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
            end
            S_MEM_WR: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.mem_we  = 1'b1;
                ctrl_c.iord    = 1'b1;
                state_d        = bus.mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_WB_MEM: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                state_d           = S_FETCH;
            end
            S_WB_ALU: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = (bus.opcode == OP_RTYPE);
                state_d          = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_c.sel_operA = SELA_REG;
                ctrl_c.sel_operB = SELB_RS;
                ctrl_c.alu_ctrl  = ALU_SUB;
                ctrl_c.pc_src    = PCSRC_ALUOUT;
                ctrl_c.pc_write  = bus.zero;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                ctrl_c.pc_src   = PCSRC_JUMP;
                ctrl_c.pc_write = 1'b1;
                state_d         = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_req    = ctrl_c.mem_req;
    assign bus.mem_we     = ctrl_c.mem_we;
    assign bus.iord       = ctrl_c.iord;
    assign bus.ir_write   = ctrl_c.ir_write;
    assign bus.pc_write   = ctrl_c.pc_write;
    assign bus.pc_src     = ctrl_c.pc_src;
    assign bus.reg_write  = ctrl_c.reg_write;
    assign bus.reg_dst    = ctrl_c.reg_dst;
    assign bus.mem_to_reg = ctrl_c.mem_to_reg;
    assign bus.sel_operA  = ctrl_c.sel_operA;
    assign bus.sel_operB  = ctrl_c.sel_operB;
    assign bus.alu_ctrl   = ctrl_c.alu_ctrl;
    assign bus.illegal_op = ctrl_c.illegal_op;
    assign bus.state_dbg  = STATE_W'(state_q);

endmodule
